// File: rtl/bpc_pkg.sv
// ============================================================================
// Module      : bpc_pkg
// Description : Shared types and defaults for the branch-prediction control
//               block: FSM state encoding, prediction-pipe entry layout and
//               a PC arithmetic helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpc_pkg;

    // Default statistics counter width and sequential fetch step in bytes.
    localparam int unsigned BPC_CNT_W  = 16;
    localparam int unsigned BPC_PC_INC = 4;

    // RUN: normal operation. PEND: a redirect is waiting for the stall to drop.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } bpc_state_e;

    // One in-flight prediction record carried alongside the instruction.
    typedef struct packed {
        logic        valid;
        logic        pt;
        logic [31:0] target;
    } pred_entry_t;

    localparam pred_entry_t PRED_ENTRY_EMPTY = '{valid: 1'b0, pt: 1'b0, target: 32'h0};

    // Wrapping 32-bit PC advance.
    function automatic logic [31:0] pc_add(input logic [31:0] pc, input int unsigned inc);
        return pc + inc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpc_pred_pipe.sv
// ============================================================================
// Module      : bpc_pred_pipe
// Description : Two-stage (ID, EX) shift register for prediction records.
//               Shifts when not stalled; a flush invalidates both stages and
//               takes priority over the shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import bpc_pkg::*;

module bpc_pred_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  pred_entry_t if_entry,
    output pred_entry_t ex_entry
);

    pred_entry_t id_q;
    pred_entry_t id_d;
    pred_entry_t ex_q;
    pred_entry_t ex_d;

    // Next-stage contents: flush squashes, otherwise shift unless stalled.
    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (flush) begin
            // The IF record belongs to the wrong path, so nothing is loaded.
            id_d = PRED_ENTRY_EMPTY;
            ex_d = PRED_ENTRY_EMPTY;
        end else if (!stall) begin
            id_d = if_entry;
            ex_d = id_q;
        end
    end

    // Stage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q <= PRED_ENTRY_EMPTY;
            ex_q <= PRED_ENTRY_EMPTY;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign ex_entry = ex_q;

endmodule

`default_nettype wire

// File: rtl/bpc_ctrl.sv
// ============================================================================
// Module      : bpc_ctrl
// Description : Branch-prediction PC controller. Selects the next fetch PC
//               from the BHT lookup, detects EX-stage mispredictions, issues
//               the same-cycle redirect/flush, defers it while stalled, and
//               keeps saturating branch / misprediction counters.
//               Optional feature macro: BPC_STATS_EN (counters present when
//               defined; outputs tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import bpc_pkg::*;

module bpc_ctrl #(
    parameter int unsigned CNT_W  = BPC_CNT_W,
    parameter int unsigned PC_INC = BPC_PC_INC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      IF_PC,
    input  logic             IF_PC_hit,
    input  logic             Pred_Jump,
    input  logic [31:0]      PC_des_out,
    input  logic             EX_Branch,
    input  logic             Branch_Success,
    input  logic [31:0]      EX_PC,
    input  logic [31:0]      EX_target,
    output logic [31:0]      next_pc,
    output logic             flush,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    bpc_state_e  state_q;
    bpc_state_e  state_d;
    logic [31:0] rpc_q;
    logic [31:0] rpc_d;

    logic        if_pt;
    pred_entry_t if_entry;
    pred_entry_t ex_entry;
    logic [31:0] seq_pc;
    logic [31:0] rpc;
    logic        ex_mis;

    assign if_pt    = IF_PC_hit & Pred_Jump;
    assign if_entry = '{valid: 1'b1, pt: if_pt, target: PC_des_out};
    assign seq_pc   = pc_add(IF_PC, PC_INC);
    assign rpc      = Branch_Success ? EX_target : pc_add(EX_PC, PC_INC);

    // A squashed EX slot can never mispredict; a not-taken/not-taken match is
    // correct regardless of the recorded target.
    assign ex_mis = EX_Branch & ex_entry.valid &
                    ((ex_entry.pt != Branch_Success) |
                     (Branch_Success & (ex_entry.target != EX_target)));

    bpc_pred_pipe u_pred_pipe (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .if_entry (if_entry),
        .ex_entry (ex_entry)
    );

    // Redirect FSM next-state and same-cycle PC / flush / pulse outputs.
    always_comb begin
        state_d    = state_q;
        rpc_d      = rpc_q;
        next_pc    = if_pt ? PC_des_out : seq_pc;
        flush      = 1'b0;
        mispredict = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_mis) begin
                    if (!stall) begin
                        next_pc    = rpc;
                        flush      = 1'b1;
                        mispredict = 1'b1;
                    end else begin
                        // Pipeline frozen: remember where to go and redirect later.
                        rpc_d   = rpc;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                // EX inputs are ignored here; the latched target is authoritative.
                next_pc = rpc_q;
                if (!stall) begin
                    flush      = 1'b1;
                    mispredict = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM state and latched recovery PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            rpc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            rpc_q   <= rpc_d;
        end
    end

`ifdef BPC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             br_accept;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d;

    // A branch is accepted when it leaves EX: normally in RUN, or when a
    // deferred mispredict finally redirects on leaving PEND.
    always_comb begin
        br_accept     = 1'b0;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!stall) begin
            if (state_q == RUN) begin
                br_accept = EX_Branch & ex_entry.valid;
            end else begin
                br_accept = 1'b1;
            end
        end
        if (br_accept && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bpc_ctrl.sv
// ============================================================================
// Module      : tb_bpc_ctrl
// Description : Self-checking bench for bpc_ctrl: directed scenarios plus a
//               randomized run against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpc_ctrl;

    // Narrow counters so saturation is reachable in a short run.
    localparam int TB_CNT_W = 5;
    localparam logic [31:0] CMAX = 32'((1 << TB_CNT_W) - 1);
`ifdef BPC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                stall = 1'b1;
    logic [31:0]         IF_PC = 32'h0;
    logic                IF_PC_hit = 1'b0;
    logic                Pred_Jump = 1'b0;
    logic [31:0]         PC_des_out = 32'h0;
    logic                EX_Branch = 1'b0;
    logic                Branch_Success = 1'b0;
    logic [31:0]         EX_PC = 32'h0;
    logic [31:0]         EX_target = 32'h0;
    logic [31:0]         next_pc;
    logic                flush;
    logic                mispredict;
    logic [TB_CNT_W-1:0] branch_cnt;
    logic [TB_CNT_W-1:0] mispred_cnt;

    bpc_ctrl #(.CNT_W(TB_CNT_W), .PC_INC(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .IF_PC          (IF_PC),
        .IF_PC_hit      (IF_PC_hit),
        .Pred_Jump      (Pred_Jump),
        .PC_des_out     (PC_des_out),
        .EX_Branch      (EX_Branch),
        .Branch_Success (Branch_Success),
        .EX_PC          (EX_PC),
        .EX_target      (EX_target),
        .next_pc        (next_pc),
        .flush          (flush),
        .mispredict     (mispredict),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model: in-flight predictions as a two-slot list
    // (slot 0 = younger, slot 1 = oldest, i.e. in EX).
    typedef struct {
        bit        v;
        bit        pt;
        bit [31:0] tgt;
    } slot_t;

    slot_t     slots[2];
    bit        pend;
    bit [31:0] held;
    bit [31:0] exp_br;
    bit [31:0] exp_mp;

    task automatic model_reset();
        slots[0] = '{v: 1'b0, pt: 1'b0, tgt: 32'h0};
        slots[1] = '{v: 1'b0, pt: 1'b0, tgt: 32'h0};
        pend   = 1'b0;
        held   = 32'h0;
        exp_br = 32'h0;
        exp_mp = 32'h0;
    endtask

    // One clock: drive inputs, compare DUT with model, advance the model.
    task automatic step(input bit s, input bit [31:0] ifpc, input bit hit, input bit pj,
                        input bit [31:0] des, input bit exb, input bit bs,
                        input bit [31:0] expc, input bit [31:0] extgt);
        bit        pt_if;
        bit        wrong;
        bit        e_fl;
        bit        e_mp;
        bit        chk_pc;
        bit        acc;
        bit [31:0] e_pc;
        bit [31:0] rpc_now;
        @(negedge clk);
        stall = s; IF_PC = ifpc; IF_PC_hit = hit; Pred_Jump = pj; PC_des_out = des;
        EX_Branch = exb; Branch_Success = bs; EX_PC = expc; EX_target = extgt;
        #1;
        pt_if   = hit & pj;
        rpc_now = bs ? extgt : expc + 32'd4;
        wrong   = slots[1].v && exb &&
                  ((slots[1].pt != bs) || (bs && (slots[1].tgt != extgt)));
        e_pc    = pt_if ? des : ifpc + 32'd4;
        e_fl    = 1'b0;
        e_mp    = 1'b0;
        chk_pc  = 1'b1;
        acc     = 1'b0;
        if (pend) begin
            e_pc = held;
            if (!s) begin
                e_fl = 1'b1; e_mp = 1'b1; acc = 1'b1; pend = 1'b0;
            end
        end else begin
            acc = exb && slots[1].v && !s;
            if (wrong && !s) begin
                e_pc = rpc_now; e_fl = 1'b1; e_mp = 1'b1;
            end else if (wrong) begin
                // Fetch PC is frozen this cycle; its value is not defined.
                chk_pc = 1'b0; pend = 1'b1; held = rpc_now;
            end
        end
        if (chk_pc) check_eq("next_pc", next_pc, e_pc);
        check_eq("flush", 32'(flush), 32'(e_fl));
        check_eq("mispredict", 32'(mispredict), 32'(e_mp));
        check_eq("branch_cnt", 32'(branch_cnt), STATS ? exp_br : 32'h0);
        check_eq("mispred_cnt", 32'(mispred_cnt), STATS ? exp_mp : 32'h0);
        if (acc && exp_br < CMAX) exp_br++;
        if (e_mp && exp_mp < CMAX) exp_mp++;
        if (e_fl) begin
            slots[0].v = 1'b0;
            slots[1].v = 1'b0;
        end else if (!s) begin
            slots[1] = slots[0];
            slots[0] = '{v: 1'b1, pt: pt_if, tgt: des};
        end
    endtask

    // Asynchronous reset pulse between clock edges; leaves stall high so the
    // following edge changes nothing.
    task automatic do_reset(input string tag);
        @(negedge clk);
        stall = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_eq({tag, "_pc"}, next_pc,
                 (IF_PC_hit & Pred_Jump) ? PC_des_out : IF_PC + 32'd4);
        check_eq({tag, "_flush"}, 32'(flush), 32'h0);
        check_eq({tag, "_mp"}, 32'(mispredict), 32'h0);
        check_eq({tag, "_bcnt"}, 32'(branch_cnt), 32'h0);
        check_eq({tag, "_mcnt"}, 32'(mispred_cnt), 32'h0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [31:0] tg [4] = '{32'h100, 32'h180, 32'h200, 32'h240};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_flush", 32'(flush), 32'h0);
        check_eq("reset_mp", 32'(mispredict), 32'h0);
        check_eq("reset_bcnt", 32'(branch_cnt), 32'h0);
        check_eq("reset_mcnt", 32'(mispred_cnt), 32'h0);
        rst = 1'b1;

        // Fetch-side prediction.
        step(1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("pred_taken_pc", next_pc, 32'h200);
        step(1'b0, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("pred_miss_pc", next_pc, 32'h104);

        // Predicted not-taken, resolved taken.
        do_reset("rst_a");
        step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        step(1'b0, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        check_eq("nt_taken_pc", next_pc, 32'h180);
        check_eq("nt_taken_flush", 32'(flush), 32'h1);
        check_eq("nt_taken_mp", 32'(mispredict), 32'h1);
        idle();
        check_eq("nt_taken_mcnt", 32'(mispred_cnt), STATS ? 32'h1 : 32'h0);

        // Predicted taken, wrong target.
        do_reset("rst_b");
        step(1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        step(1'b0, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h240);
        check_eq("tgt_wrong_pc", next_pc, 32'h240);
        check_eq("tgt_wrong_flush", 32'(flush), 32'h1);
        // Predicted taken, resolved not taken.
        do_reset("rst_c");
        step(1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        step(1'b0, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h240);
        check_eq("t_nt_pc", next_pc, 32'h104);

        // Mispredict under a three-cycle stall.
        do_reset("rst_d");
        step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        step(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        check_eq("stall1_flush", 32'(flush), 32'h0);
        step(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h999);
        check_eq("stall2_pc", next_pc, 32'h180);
        step(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h999);
        check_eq("stall3_flush", 32'(flush), 32'h0);
        step(1'b0, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h999);
        check_eq("pend_exit_pc", next_pc, 32'h180);
        check_eq("pend_exit_flush", 32'(flush), 32'h1);
        check_eq("pend_exit_mp", 32'(mispredict), 32'h1);
        idle();
        check_eq("pend_exit_mp_again", 32'(mispredict), 32'h0);
        check_eq("pend_bcnt", 32'(branch_cnt), STATS ? 32'h1 : 32'h0);
        check_eq("pend_mcnt", 32'(mispred_cnt), STATS ? 32'h1 : 32'h0);

        // Back-to-back mispredicting branches: younger one is squashed.
        do_reset("rst_e");
        step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        check_eq("b2b_first_flush", 32'(flush), 32'h1);
        step(1'b0, 32'h180, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h180);
        check_eq("b2b_second_flush", 32'(flush), 32'h0);
        idle();
        check_eq("b2b_bcnt", 32'(branch_cnt), STATS ? 32'h1 : 32'h0);

        // Reset while a redirect is pending.
        do_reset("rst_f");
        step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        step(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        step(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        do_reset("rst_pend");
        step(1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        check_eq("after_pend_rst_pc", next_pc, 32'h304);

        // Saturation: every valid EX slot mispredicts.
        do_reset("rst_g");
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180);
        end
        check_eq("sat_mcnt", 32'(mispred_cnt), STATS ? CMAX : 32'h0);
        check_eq("sat_bcnt", 32'(branch_cnt), STATS ? CMAX : 32'h0);

        // Randomized run.
        do_reset("rst_r");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rst_rand");
            end
            step($urandom_range(0, 3) == 0,
                 32'($urandom_range(0, 255)) << 2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 tg[$urandom_range(0, 3)],
                 $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)) << 2,
                 tg[$urandom_range(0, 3)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bpc_ctrl.md
BPC_CTRL -- requirements
Module: bpc_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of each statistics counter.
REQ-002 Parameter PC_INC, default 4: sequential PC increment in bytes.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  pipeline hold; prediction pipe and FSM hold while high.
REQ-006 IF_PC  in  32  fetch PC.
REQ-007 IF_PC_hit / Pred_Jump / PC_des_out  in  1/1/32  BHT lookup result for IF_PC.
REQ-008 EX_Branch / Branch_Success  in  1/1  EX holds a branch / branch resolved taken.
REQ-009 EX_PC / EX_target  in  32/32  EX branch PC / resolved target.
REQ-010 next_pc  out  32  PC to load into the fetch register.
REQ-011 flush  out  1  squash IF/ID and ID/EX contents.
REQ-012 mispredict  out  1  single-cycle pulse, EX misprediction accepted.
REQ-013 branch_cnt / mispred_cnt  out  CNT_W/CNT_W  statistics counters.

Function
REQ-014 Predicted-taken at IF: pt = IF_PC_hit & Pred_Jump; next_pc = pt ? PC_des_out : IF_PC+PC_INC (mod 2^32) in RUN with no redirect.
REQ-015 Each cycle stall=0: {valid=1, pt, PC_des_out} shifts IF->ID->EX; stall=1: all stages hold.
REQ-016 EX misprediction m = EX_Branch & ex_valid & ((ex_pt != Branch_Success) | (Branch_Success & ex_target != EX_target)).
REQ-017 Recovery PC rpc = Branch_Success ? EX_target : EX_PC+PC_INC.
REQ-018 FSM states RUN, PEND. RUN & m & !stall: same cycle next_pc=rpc, flush=1, mispredict=1; stay RUN.
REQ-019 RUN & m & stall: latch rpc, go PEND; no flush, no pulse that cycle.
REQ-020 PEND & stall: hold; next_pc=latched rpc, flush=0.
REQ-021 PEND & !stall: next_pc=latched rpc, flush=1, mispredict=1, go RUN; EX evaluation suppressed that cycle.
REQ-022 flush=1 clears ID and EX valid bits on the same edge (flush overrides the shift); IF stage loads nothing.
REQ-023 Squashed (valid=0) EX entries never produce m and never count.
REQ-024 branch_cnt +1 per accepted EX branch (EX_Branch & ex_valid & !stall in RUN); mispred_cnt +1 per mispredict pulse; both saturate at 2^CNT_W-1, no wrap.
REQ-025 Not-taken predicted and not taken: no flush, no redirect regardless of target mismatch.

Reset
REQ-026 rst low: state=RUN, all valid bits 0, latched rpc 0, counters 0, flush=0, mispredict=0, immediately (asynchronous).
REQ-027 Reset mid-PEND discards pending redirect; first cycle after release: next_pc follows REQ-014.

Configuration
REQ-028 BPC_STATS_EN defined: counters per REQ-024.
REQ-029 BPC_STATS_EN undefined: no counter flops; branch_cnt and mispred_cnt tied to 0.

Structure
REQ-030 Package bpc_pkg holds state enum {RUN, PEND}, PC_INC default, CNT_W default, and prediction-entry struct {valid, pt, target[31:0]}.
REQ-031 Sub-module bpc_pred_pipe implements the two-stage prediction shift register with stall/flush; FSM and counters live in bpc_ctrl.

Verification
REQ-032 IF_PC=0x100, hit=1, Pred_Jump=1, PC_des_out=0x200 -> next_pc=0x200; hit=0 -> next_pc=0x104.
REQ-033 Predicted not-taken branch at 0x100 reaches EX, Branch_Success=1, EX_target=0x180 -> same cycle next_pc=0x180, flush=1, mispredict=1, mispred_cnt=1.
REQ-034 Predicted taken to 0x200, resolved taken EX_target=0x240 -> next_pc=0x240, flush=1; resolved not taken at EX_PC=0x100 -> next_pc=0x104.
REQ-035 Mispredict with stall=1 for 3 cycles -> PEND, flush=0 for 3 cycles, then one cycle flush=1, next_pc=rpc, single pulse, counters +1 once.
REQ-036 Back-to-back mispredicting branches in ID and EX -> only EX one flushes; younger squashed, never counted (branch_cnt=1).
REQ-037 Force mispred_cnt to 0xFFFF (CNT_W=16), another mispredict -> stays 0xFFFF; rst low in PEND -> counters 0, state RUN.
